vpu_opget_unit: RTL and testbench

- Operand-fetch stage of the VPU, directly downstream of the VPU controller's GETOP handshake (opget_start / opget_done).
- On start, reads each enabled source operand from its SRAM read port as SRC_BEATS consecutive beats and pushes the beats into a per-source operand queue.
- The queues feed the execution stage, which pops them via operand_queue_rden.
- Pulses done once every enabled source has all its beats queued.

---
 rtl/vpu_opget_unit.sv | 161 ++++++++++++++++
 tb/tb_vpu_opget_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_opget_unit.sv
// VPU operand-fetch stage: reads enabled source operands from SRAM
// and queues their beats for the execution stage.
module vpu_opget_unit #(
    parameter int SRC_CNT   = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 512,
    parameter int SRC_BEATS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        opget_start_i,
    input  logic [SRC_CNT-1:0]          src_valid_i,
    input  logic [SRC_CNT*ADDR_W-1:0]   src_addr_i,
    output logic                        opget_done_o,
    output logic                        busy_o,
    output logic [SRC_CNT-1:0]          sram_rden_o,
    output logic [SRC_CNT*ADDR_W-1:0]   sram_raddr_o,
    input  logic [SRC_CNT-1:0]          sram_rvalid_i,
    input  logic [SRC_CNT*DATA_W-1:0]   sram_rdata_i,
    input  logic [SRC_CNT-1:0]          operand_queue_rden_i,
    output logic [SRC_CNT*DATA_W-1:0]   operand_data_o,
    output logic [SRC_CNT-1:0]          operand_empty_o,
    output logic                        err_o
);

    localparam int CW = $clog2(SRC_BEATS + 1);
    localparam int PW = (SRC_BEATS > 1) ? $clog2(SRC_BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                      state;
    logic [SRC_CNT-1:0]          mask;
    logic [SRC_CNT*ADDR_W-1:0]   base;
    logic [PW-1:0]               beat;
    logic [SRC_CNT-1:0][CW-1:0]  ret_cnt;
    logic [SRC_CNT-1:0][CW-1:0]  ret_nxt;
    logic [SRC_CNT*ADDR_W-1:0]   raddr_nxt;
    logic [SRC_CNT-1:0]          hit, push, pop, full, empty;
    logic                        active, ret_done, err_set;

    assign active = (state != S_IDLE);
    assign busy_o = active;
    assign hit    = sram_rvalid_i & mask & {SRC_CNT{active}};
    assign operand_empty_o = empty;

    always_comb begin
        ret_done  = 1'b1;
        ret_nxt   = ret_cnt;
        raddr_nxt = '0;
        for (int k = 0; k < SRC_CNT; k++) begin
            ret_nxt[k] = ret_cnt[k] + CW'(hit[k]);
            if (mask[k] && ret_nxt[k] != CW'(SRC_BEATS))
                ret_done = 1'b0;
            raddr_nxt[k*ADDR_W +: ADDR_W] =
                base[k*ADDR_W +: ADDR_W] + ADDR_W'(beat) + ADDR_W'(1);
        end
    end

    // Every protocol violation folds into one sticky flag.
    assign err_set = (opget_start_i & active)
                   | (|(sram_rvalid_i & ~(mask & {SRC_CNT{active}})))
                   | (|(hit & full & ~pop))
                   | (|(operand_queue_rden_i & empty));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            mask         <= '0;
            base         <= '0;
            beat         <= '0;
            ret_cnt      <= '0;
            opget_done_o <= 1'b0;
            sram_rden_o  <= '0;
            sram_raddr_o <= '0;
            err_o        <= 1'b0;
        end else begin
            opget_done_o <= 1'b0;
            ret_cnt      <= ret_nxt;
            if (err_set)
                err_o <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (opget_start_i) begin
                        mask <= src_valid_i;
                        base <= src_addr_i;
                        beat <= '0;
                        if (|src_valid_i) begin
                            state        <= S_ISSUE;
                            sram_rden_o  <= src_valid_i;
                            sram_raddr_o <= src_addr_i;
                        end else begin
                            state        <= S_DONE;
                            opget_done_o <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (beat == PW'(SRC_BEATS - 1)) begin
                        state       <= S_WAIT;
                        sram_rden_o <= '0;
                    end else begin
                        beat         <= beat + 1'b1;
                        sram_raddr_o <= raddr_nxt;
                    end
                end
                S_WAIT: begin
                    if (ret_done) begin
                        state        <= S_DONE;
                        opget_done_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    mask    <= '0;
                    beat    <= '0;
                    ret_cnt <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < SRC_CNT; k++) begin : g_q
        logic [DATA_W-1:0] mem [SRC_BEATS];
        logic [PW-1:0]     wp, rp;
        logic [CW-1:0]     cnt;

        assign full[k]  = (cnt == CW'(SRC_BEATS));
        assign empty[k] = (cnt == '0);
        assign pop[k]   = operand_queue_rden_i[k] & ~empty[k];
        assign push[k]  = hit[k] & (~full[k] | pop[k]);

        assign operand_data_o[k*DATA_W +: DATA_W] =
            empty[k] ? '0 : mem[rp];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push[k])
                    wp <= (wp == PW'(SRC_BEATS - 1)) ? '0 : wp + 1'b1;
                if (pop[k])
                    rp <= (rp == PW'(SRC_BEATS - 1)) ? '0 : rp + 1'b1;
                cnt <= cnt + CW'(push[k]) - CW'(pop[k]);
            end
        end

        always_ff @(posedge clk) begin
            if (push[k])
                mem[wp] <= sram_rdata_i[k*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_vpu_opget_unit.sv
// Directed bench for vpu_opget_unit with a two-cycle SRAM read model.
module tb_vpu_opget_unit;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            opget_start_i = 1'b0;
    logic [N-1:0]    src_valid_i = '0;
    logic [N*AW-1:0] src_addr_i = '0;
    logic            opget_done_o, busy_o, err_o;
    logic [N-1:0]    sram_rden_o, sram_rvalid_i, operand_empty_o;
    logic [N*AW-1:0] sram_raddr_o;
    logic [N*DW-1:0] sram_rdata_i, operand_data_o;
    logic [N-1:0]    operand_queue_rden_i = '0;

    logic [N-1:0]    p1 = '0, p2 = '0, inj_v = '0;
    logic [N*AW-1:0] a1 = '0, a2 = '0;
    logic [DW-1:0]   inj_d = '0;

    logic [N-1:0]    rd_log [8];
    logic [N*AW-1:0] ad_log [8];
    logic            dn_log [8];
    logic            by_log [8];

    int n_chk  = 0;
    int n_pass = 0;

    vpu_opget_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .opget_start_i        (opget_start_i),
        .src_valid_i          (src_valid_i),
        .src_addr_i           (src_addr_i),
        .opget_done_o         (opget_done_o),
        .busy_o               (busy_o),
        .sram_rden_o          (sram_rden_o),
        .sram_raddr_o         (sram_raddr_o),
        .sram_rvalid_i        (sram_rvalid_i),
        .sram_rdata_i         (sram_rdata_i),
        .operand_queue_rden_i (operand_queue_rden_i),
        .operand_data_o       (operand_data_o),
        .operand_empty_o      (operand_empty_o),
        .err_o                (err_o)
    );

    always #5 clk = ~clk;

    // SRAM model: data word is {8'hA0+port, address}.
    always @(posedge clk) begin
        p1 <= sram_rden_o;
        a1 <= sram_raddr_o;
        p2 <= p1;
        a2 <= a1;
    end

    always_comb begin
        sram_rvalid_i = p2 | inj_v;
        sram_rdata_i  = '0;
        for (int k = 0; k < N; k++) begin
            if (p2[k])
                sram_rdata_i[k*DW +: DW] =
                    DW'({8'hA0 + 8'(k), a2[k*AW +: AW]});
            else if (inj_v[k])
                sram_rdata_i[k*DW +: DW] = inj_d;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fetch(input logic [N-1:0] m, input logic [N*AW-1:0] a,
                         input int sc, input int ic, input logic [N-1:0] iv);
        @(posedge clk);
        #1;
        opget_start_i = 1'b1;
        src_valid_i   = m;
        src_addr_i    = a;
        @(posedge clk);
        #1 opget_start_i = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            rd_log[c] = sram_rden_o;
            ad_log[c] = sram_raddr_o;
            dn_log[c] = opget_done_o;
            by_log[c] = busy_o;
            opget_start_i = (c == sc);
            inj_v = (c == ic) ? iv : '0;
        end
    endtask

    task automatic pop(input logic [N-1:0] m);
        @(posedge clk);
        #1 operand_queue_rden_i = m;
        @(posedge clk);
        #1 operand_queue_rden_i = '0;
    endtask

    function automatic logic [DW-1:0] head(input int k);
        return operand_data_o[k*DW +: DW];
    endfunction

    initial begin
        inj_d = DW'(24'hDEAD00);
        @(negedge clk);
        chk("rst_done", opget_done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rden", sram_rden_o, 0);
        chk("rst_raddr", sram_raddr_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_empty", operand_empty_o, 3'b111);
        chk("rst_data", operand_data_o[DW-1:0], 0);
        #1 rst = 1'b0;

        // full fetch
        fetch(3'b111, {16'h0030, 16'h0020, 16'h0010}, 0, 0, '0);
        chk("full_rden1", rd_log[1], 3'b111);
        chk("full_rden2", rd_log[2], 3'b111);
        chk("full_rden3", rd_log[3], 3'b000);
        chk("full_addr1", ad_log[1], {16'h0030, 16'h0020, 16'h0010});
        chk("full_addr2", ad_log[2], {16'h0031, 16'h0021, 16'h0011});
        for (int c = 1; c < 8; c++) begin
            chk($sformatf("full_done%0d", c), dn_log[c], c == 5);
            chk($sformatf("full_busy%0d", c), by_log[c], c <= 5);
        end
        chk("full_empty", operand_empty_o, 3'b000);
        chk("full_h0a", head(0), 24'hA00010);
        chk("full_h1a", head(1), 24'hA10020);
        chk("full_h2a", head(2), 24'hA20030);
        pop(3'b111);
        chk("full_h0b", head(0), 24'hA00011);
        chk("full_h1b", head(1), 24'hA10021);
        chk("full_h2b", head(2), 24'hA20031);
        pop(3'b111);
        chk("full_drain", operand_empty_o, 3'b111);
        chk("full_err", err_o, 0);

        // partial mask and drain
        fetch(3'b101, {16'h0300, 16'h0200, 16'h0100}, 0, 0, '0);
        chk("part_rden1", rd_log[1], 3'b101);
        chk("part_rden2", rd_log[2], 3'b101);
        chk("part_done4", dn_log[4], 0);
        chk("part_done5", dn_log[5], 1);
        chk("part_empty", operand_empty_o, 3'b010);
        chk("part_h0a", head(0), 24'hA00100);
        chk("part_h2a", head(2), 24'hA20300);
        pop(3'b101);
        chk("part_h0b", head(0), 24'hA00101);
        chk("part_h2b", head(2), 24'hA20301);
        pop(3'b101);
        chk("part_drain", operand_empty_o, 3'b111);
        chk("part_data", operand_data_o[DW-1:0], 0);
        chk("part_err", err_o, 0);

        // zero mask
        fetch(3'b000, {16'h0001, 16'h0002, 16'h0003}, 0, 0, '0);
        chk("zero_done1", dn_log[1], 1);
        chk("zero_done2", dn_log[2], 0);
        chk("zero_rden1", rd_log[1], 0);
        chk("zero_busy2", by_log[2], 0);
        chk("zero_err", err_o, 0);

        // address wrap
        fetch(3'b001, {16'h0000, 16'h0000, 16'hFFFF}, 0, 0, '0);
        chk("wrap_a1", ad_log[1][AW-1:0], 16'hFFFF);
        chk("wrap_a2", ad_log[2][AW-1:0], 16'h0000);
        chk("wrap_h0a", head(0), 24'hA0FFFF);
        pop(3'b001);
        chk("wrap_h0b", head(0), 24'hA00000);
        pop(3'b001);
        chk("wrap_err", err_o, 0);

        // start during S_WAIT
        do_reset();
        chk("sw_err0", err_o, 0);
        fetch(3'b111, {16'h0030, 16'h0020, 16'h0010}, 3, 0, '0);
        chk("sw_done4", dn_log[4], 0);
        chk("sw_done5", dn_log[5], 1);
        chk("sw_done6", dn_log[6], 0);
        chk("sw_busy7", by_log[7], 0);
        chk("sw_err", err_o, 1);
        chk("sw_h1", head(1), 24'hA10020);
        pop(3'b111);
        pop(3'b111);
        chk("sw_drain", operand_empty_o, 3'b111);

        // pop of an empty queue
        do_reset();
        pop(3'b100);
        chk("pe_err", err_o, 1);
        chk("pe_empty", operand_empty_o, 3'b111);

        // rvalid on an unmasked port
        do_reset();
        fetch(3'b001, {16'h0030, 16'h0020, 16'h0010}, 0, 3, 3'b010);
        chk("um_done5", dn_log[5], 1);
        chk("um_err", err_o, 1);
        chk("um_empty", operand_empty_o, 3'b110);
        chk("um_h1", head(1), 0);
        pop(3'b001);
        pop(3'b001);

        // reset mid-operation
        do_reset();
        @(posedge clk);
        #1;
        opget_start_i = 1'b1;
        src_valid_i   = 3'b111;
        src_addr_i    = {16'h0030, 16'h0020, 16'h0010};
        @(posedge clk);
        #1 opget_start_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mr_busy", busy_o, 0);
        chk("mr_rden", sram_rden_o, 0);
        chk("mr_raddr", sram_raddr_o, 0);
        chk("mr_done", opget_done_o, 0);
        chk("mr_empty", operand_empty_o, 3'b111);
        chk("mr_err0", err_o, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic any_done;
            any_done = 1'b0;
            for (int c = 3; c < 7; c++) begin
                @(negedge clk);
                any_done |= opget_done_o;
                if (c == 4) begin
                    chk("mr_err", err_o, 1);
                    chk("mr_dropped", operand_empty_o, 3'b111);
                end
            end
            chk("mr_nodone", any_done, 0);
        end
        fetch(3'b111, {16'h0130, 16'h0120, 16'h0110}, 0, 0, '0);
        chk("mr2_done5", dn_log[5], 1);
        chk("mr2_h0a", head(0), 24'hA00110);
        chk("mr2_h2a", head(2), 24'hA20130);
        pop(3'b111);
        chk("mr2_h1b", head(1), 24'hA10121);
        pop(3'b111);
        chk("mr2_drain", operand_empty_o, 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
